i2s_mix_transmitter: RTL
========================

# i2s_mix_transmitter

Output stage directly downstream of the voice mixer. Consumes the mixer's mono sample stream (`mixed_out`/`data_out_valid`), scales and saturates each sample to DAC width, buffers it in a small FIFO, and serialises it as a free-running I2S master (BCLK, LRCLK, SDATA). The same sample goes to the left and right slots. Underrun and overflow are reported as single-cycle pulses.

## Interface
- `DATA_WIDTH`, 32: input sample width (signed), matching the mixer output.
- `AUDIO_WIDTH`, 24: serialised sample width; must be ≤ 32.
- `MIX_SHIFT`, 3: arithmetic right shift applied before narrowing (headroom for 8 summed voices).
- `BCLK_DIV`, 16: clk cycles per BCLK half-period; ≥ 2.
- `FIFO_DEPTH`, 4: sample FIFO depth; power of two, ≥ 2.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `sample_in` in DATA_WIDTH: signed mixed sample.
- `sample_in_valid` in 1: `sample_in` is valid this cycle.
- `sample_ready` out 1: FIFO not full.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrclk` out 1: word select; 0 = left.
- `i2s_sdata` out 1: serial data, MSB first.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `underrun` out 1: one-cycle pulse when a frame loads from an empty FIFO.
- `overflow` out 1: one-cycle pulse when a valid sample is dropped.
- `clip` out 1: one-cycle pulse when an accepted sample saturated.

## Operation
- **Conversion (combinational, before the FIFO):** `s = sample_in >>> MIX_SHIFT`, then narrowed to AUDIO_WIDTH. Narrowing is saturating or wrapping, as set under Configuration.
- **FIFO push:** when `sample_in_valid` is high and the FIFO is not full, or is full but pops in the same cycle.
  - If `sample_in_valid` is high, the FIFO is full and there is no pop: drop the sample and pulse `overflow` for one cycle.
- **BCLK generator:** `div_cnt` counts 0..BCLK_DIV-1. At terminal count `i2s_bclk` toggles.
  - A "fall event" is terminal count while `i2s_bclk`=1.
- **Bit counter:** `bit_cnt` is 6 bits, range 0..63, and increments (wrapping) on each fall event.
  - All serial outputs update only on fall events, in the same clk edge as the BCLK fall.
- **LRCLK:** 1 when `bit_cnt` ∈ 31..62; 0 when `bit_cnt` ∈ {63, 0..30}. This gives standard I2S one-bit delay.
- **Frame load:** on the fall event entering `bit_cnt`=63, pop the FIFO head into the frame register.
  - If the FIFO is empty, load zero and pulse `underrun` for one cycle.
  - A push in that same cycle into an empty FIFO is stored; it does not rescue the frame.
- **SDATA:**
  - `bit_cnt` 0..AUDIO_WIDTH-1 → left slot, frame bits MSB..LSB.
  - `bit_cnt` 32..32+AUDIO_WIDTH-1 → right slot, the same bits.
  - All other slot positions → 0.

## Timing
- **Reset values:**
  - `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_sdata`=0.
  - `div_cnt`=0, `bit_cnt`=63, frame register=0.
  - FIFO empty, `fifo_level`=0, `sample_ready`=1.
  - `underrun`=0, `overflow`=0, `clip`=0.
- **First frame after reset:** all zeros, with no `underrun` pulse; the first pop happens at the next entry to 63.
- **BCLK:** period is 2·BCLK_DIV clk; first rising edge is BCLK_DIV clks after reset release.
- **Frame:** 64 BCLK = 128·BCLK_DIV clk (2048 clk at default).
- **Input path:**
  - Push latency is 1 clk: `fifo_level` and `sample_ready` reflect a push on the next cycle.
  - `clip` and `overflow` assert in the cycle after the offending input.
- **Pop:** on a frame load, `fifo_level` decrements on the next cycle.
- **Mid-operation reset:** asserting `rst` at any point forces all reset values immediately (asynchronously). FIFO contents are discarded.

## Configuration
- **`I2S_MIX_TX_SATURATE_EN` defined:**
  - Narrowing saturates to [-2^(AUDIO_WIDTH-1), 2^(AUDIO_WIDTH-1)-1].
  - `clip` pulses for each accepted sample that was clamped.
- **Not defined:**
  - Narrowing keeps the low AUDIO_WIDTH bits of `s` (wrap).
  - `clip` is tied to 0. Port list is unchanged.

## Test plan
All scenarios use default parameters.
1. **Reset:** assert `rst`=0 mid-frame → all outputs at reset values in the same cycle; after release, the first frame's SDATA is all zero and `underrun` stays 0.
2. **Single sample:** push `0x0091A2B0` → next frame carries `0x123456` MSB-first at `bit_cnt` 0..23 and 32..55, zeros elsewhere. LRCLK low for {63, 0..30} and high for 31..62.
3. **Saturation (macro defined):**
   - Push `0x7FFFFFFF` → slots carry `0x7FFFFF` and `clip` pulses once.
   - Push `0x80000000` → slots carry `0x800000`.
   - With the macro undefined, `0x7FFFFFFF` → `0xFFFFFF` and `clip`=0.
4. **Underrun:** let the FIFO drain → frame of zeros and exactly one `underrun` pulse per empty frame load.
5. **Overflow:** 5 back-to-back valid samples with no pop → 4 accepted, `fifo_level`=4, `sample_ready`=0, one `overflow` pulse. The later 4 frames carry the first 4 samples in order.
6. **Edge case:** push into an empty FIFO in the exact frame-load cycle → zero frame plus `underrun`, and the sample is played in the following frame.

Source files
------------

// File: rtl/i2s_mix_transmitter.sv
// rtl/i2s_mix_transmitter.sv - mixer output stage: scale, sample FIFO and free-running I2S master
// Define I2S_MIX_TX_SATURATE_EN for saturating narrowing with clip pulses; otherwise samples wrap.
module i2s_mix_transmitter #(
  parameter int DATA_WIDTH  = 32,
  parameter int AUDIO_WIDTH = 24,
  parameter int MIX_SHIFT   = 3,
  parameter int BCLK_DIV    = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         sample_in,
  input  logic                          sample_in_valid,
  output logic                          sample_ready,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          overflow,
  output logic                          clip
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [PTR_W:0]   DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // ---------------- sample conversion ----------------
  logic signed [DATA_WIDTH-1:0] shifted;
  logic [AUDIO_WIDTH-1:0]       conv;
  logic                         conv_clamped;

  assign shifted = $signed(sample_in) >>> MIX_SHIFT;

`ifdef I2S_MIX_TX_SATURATE_EN
  logic over_pos;
  logic over_neg;

  // Out of range when the bits above the target sign bit disagree with the sign.
  assign over_pos = !shifted[DATA_WIDTH-1] && (|shifted[DATA_WIDTH-2:AUDIO_WIDTH-1]);
  assign over_neg = shifted[DATA_WIDTH-1] && !(&shifted[DATA_WIDTH-2:AUDIO_WIDTH-1]);
  assign conv_clamped = over_pos | over_neg;

  always_comb begin
    conv = shifted[AUDIO_WIDTH-1:0];
    if (over_pos) begin
      conv = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
    end else if (over_neg) begin
      conv = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
    end
  end
`else
  logic unused_high;

  assign conv         = shifted[AUDIO_WIDTH-1:0];
  assign conv_clamped = 1'b0;
  assign unused_high  = ^shifted[DATA_WIDTH-1:AUDIO_WIDTH];
`endif

  // ---------------- sample FIFO ----------------
  logic [AUDIO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic [PTR_W:0]         count_d;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  // ---------------- serial timing ----------------
  logic [DIV_W-1:0]       div_cnt_q;
  logic [DIV_W-1:0]       div_cnt_d;
  logic                   bclk_q;
  logic                   tc;
  logic                   fall_evt;
  logic [5:0]             bit_cnt_q;
  logic [5:0]             bit_cnt_d;
  logic                   load;
  logic [AUDIO_WIDTH-1:0] frame_q;
  logic [4:0]             slot_pos;
  logic                   lrclk_q;
  logic                   lrclk_d;
  logic                   sdata_q;
  logic                   sdata_d;
  logic                   underrun_q;
  logic                   overflow_q;
  logic                   clip_q;

  assign fifo_full  = (count_q == DEPTH_L);
  assign fifo_empty = (count_q == '0);

  assign tc        = (div_cnt_q == DIV_TC);
  assign fall_evt  = tc & bclk_q;
  assign div_cnt_d = tc ? '0 : div_cnt_q + DIV_ONE;
  assign bit_cnt_d = fall_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;

  // Frame load happens on the fall that enters slot 63; an empty FIFO plays silence.
  assign load = fall_evt && (bit_cnt_q == 6'd62);
  assign pop  = load & ~fifo_empty;
  assign push = sample_in_valid & (~fifo_full | pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Output bit for the slot being entered: both slots carry the frame MSB first.
  always_comb begin
    slot_pos = bit_cnt_d[4:0];
    lrclk_d  = (bit_cnt_d >= 6'd31) && (bit_cnt_d <= 6'd62);
    sdata_d  = 1'b0;
    for (int i = 0; i < AUDIO_WIDTH; i++) begin
      if (slot_pos == 5'(AUDIO_WIDTH - 1 - i)) begin
        sdata_d = frame_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= conv;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= 6'd63;
      frame_q    <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      if (tc) begin
        bclk_q <= ~bclk_q;
      end
      if (fall_evt) begin
        bit_cnt_q <= bit_cnt_d;
        lrclk_q   <= lrclk_d;
        sdata_q   <= sdata_d;
      end
      if (load) begin
        frame_q <= fifo_empty ? '0 : mem_q[rd_ptr_q];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q    <= count_d;
      underrun_q <= load & fifo_empty;
      overflow_q <= sample_in_valid & fifo_full & ~pop;
      clip_q     <= push & conv_clamped;
    end
  end

  assign sample_ready = ~fifo_full;
  assign fifo_level   = count_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;
  assign clip         = clip_q;

endmodule
